// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Groups the two buses that the instruction-memory loader touches:
//     - the incoming byte stream from the host/boot source (valid/ready)
//     - the IMem write port (IAddr / IDataIn / RW)
//   Signals:
//     byte_in    [7:0]  stream byte, driven by the source
//     byte_valid        byte_in is valid, driven by the source
//     byte_ready        loader takes the byte this cycle, driven by the loader
//     IAddr      [31:0] IMem byte address, driven by the loader
//     IDataIn    [31:0] IMem write data, driven by the loader
//     RW                IMem write strobe (1 = write), driven by the loader
//   Modports:
//     master : loader side (drives IMem bus and byte_ready)
//     slave  : environment side (byte source + IMem)
// -----------------------------------------------------------------------------
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        RW;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output IAddr,
    output IDataIn,
    output RW
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  IAddr,
    input  IDataIn,
    input  RW
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write-side master for the byte-addressed instruction memory. Packs a byte
//   stream four bytes at a time (little-endian) into words and writes each word
//   to consecutive word addresses of IMem before the CPU starts.
//
//   Ports:
//     CLK         system clock, rising edge
//     RST         asynchronous, active-low reset
//     start       1-cycle load request, ignored while busy
//     start_addr  first word byte-address (latched on an accepted start)
//     word_cnt    number of words to load (latched on an accepted start)
//     bus         imem_loader_if.master: byte stream in, IMem write port out
//     busy        loader is not idle
//     done        1-cycle pulse at the end of every load (ok or rejected)
//     err         load was rejected; held until the next accepted start
//     skip_cnt    words IMem silently drops (address 0 or data 0), saturating
//
//   Each word costs COLLECT (4 accepted bytes) + SETUP + WRITE + HOLD. IMem
//   writes are level-sensitive, so IAddr/IDataIn are loaded one cycle before RW
//   rises (SETUP) and held one cycle after it falls (HOLD).
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned MEM_BYTES = 71
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [31:0]         start_addr,
  input  logic [7:0]          word_cnt,
  imem_loader_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [7:0]          skip_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_SETUP   = 3'd2,
    S_WRITE   = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e      state_q,  state_d;
  logic [31:0] addr_q,   addr_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [1:0]  k_q,      k_d;
  logic [31:0] word_q,   word_d;
  logic [31:0] iaddr_q,  iaddr_d;
  logic [31:0] idata_q,  idata_d;
  logic        err_q,    err_d;
  logic [7:0]  skip_q,   skip_d;

  logic        byte_ready;
  logic        byte_fire;
  logic [31:0] word_merged;
  logic [33:0] end_addr;
  logic        reject;

  // A byte is consumed only while collecting and the source offers one.
  assign byte_fire = (state_q == S_COLLECT) && bus.byte_valid;

  // Current word with the incoming byte dropped into lane k (little-endian).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_merged[8*gi +: 8] =
        (byte_fire && (k_q == 2'(gi))) ? bus.byte_in : word_q[8*gi +: 8];
    end
  endgenerate

  // Bound check in 34 bits so a huge start_addr cannot wrap past the limit.
  assign end_addr = {2'b00, start_addr} + {24'd0, word_cnt, 2'b00};
  assign reject   = (start_addr[1:0] != 2'b00) || (end_addr > 34'(MEM_BYTES));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      word_q  <= '0;
      iaddr_q <= '0;
      idata_q <= '0;
      err_q   <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      word_q  <= word_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    word_d     = word_q;
    iaddr_d    = iaddr_q;
    idata_d    = idata_q;
    err_d      = err_q;
    skip_d     = skip_q;

    byte_ready = (state_q == S_COLLECT);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = start_addr;
          cnt_d  = word_cnt;
          k_d    = 2'd0;
          err_d  = reject;
          skip_d = 8'd0;
          if (reject || (word_cnt == 8'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (byte_fire) begin
          word_d = word_merged;
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3) begin
            // Present address/data a full cycle ahead of the strobe.
            iaddr_d = addr_q;
            idata_d = word_merged;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        state_d = S_WRITE;
      end

      S_WRITE: begin
        // IMem discards writes to address 0 and writes of zero data.
        if (((iaddr_q == 32'd0) || (idata_q == 32'd0)) && (skip_q != 8'hFF)) begin
          skip_d = skip_q + 8'd1;
        end
        state_d = S_HOLD;
      end

      S_HOLD: begin
        addr_d = addr_q + 32'd4;
        cnt_d  = cnt_q - 8'd1;
        k_d    = 2'd0;
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.byte_ready = byte_ready;
  assign bus.IAddr      = iaddr_q;
  assign bus.IDataIn    = idata_q;
  assign bus.RW         = (state_q == S_WRITE);
  assign err            = err_q;
  assign skip_cnt       = skip_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Inputs change 1 time unit after the rising
//   edge; outputs are read at the same point. A negedge monitor records every
//   RW pulse and flags any IAddr/IDataIn change adjacent to RW=1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = 32'd0;
  logic [7:0]  word_cnt = 8'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  skip_cnt;

  int checks   = 0;
  int failures = 0;

  imem_loader_if bus ();

  imem_loader #(.MEM_BYTES(71)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .start_addr (start_addr),
    .word_cnt   (word_cnt),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .skip_cnt   (skip_cnt)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Write monitor
  // ---------------------------------------------------------------------------
  logic [31:0] pa[$];
  logic [31:0] pd[$];
  int          rw_cycles = 0;
  int          glitches  = 0;
  logic        rw_prev   = 1'b0;
  logic [31:0] a_prev    = 32'd0;
  logic [31:0] d_prev    = 32'd0;

  always @(negedge CLK) begin
    if (bus.RW === 1'b1 && rw_prev !== 1'b1) begin
      pa.push_back(bus.IAddr);
      pd.push_back(bus.IDataIn);
      $display("write addr=%08h data=%08h skip_cnt=%0d", bus.IAddr, bus.IDataIn, skip_cnt);
    end
    if (bus.RW === 1'b1) rw_cycles++;
    if ((bus.RW === 1'b1 || rw_prev === 1'b1) &&
        (bus.IAddr !== a_prev || bus.IDataIn !== d_prev)) glitches++;
    rw_prev = bus.RW;
    a_prev  = bus.IAddr;
    d_prev  = bus.IDataIn;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load(input logic [31:0] a, input logic [7:0] n);
    $display("load start_addr=%08h word_cnt=%0d", a, n);
    start      = 1'b1;
    start_addr = a;
    word_cnt   = n;
    tick();
    start      = 1'b0;
  endtask

  // Sends one word as four bytes, optionally idling byte_valid one cycle
  // before each byte. Returns right after the edge that takes the 4th byte.
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      int guard;
      if (gap) begin
        bus.byte_valid = 1'b0;
        tick();
      end
      bus.byte_in    = w[8*i +: 8];
      bus.byte_valid = 1'b1;
      guard = 0;
      while (bus.byte_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) begin
        checks++;
        failures++;
        $display("FAIL byte_ready_timeout got=%b exp=1", bus.byte_ready);
      end
      tick();
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout got=%b exp=1 after %0d cycles", done, n);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    #2;
    RST = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b0;
    #2;
    checks++;
    if (bus.RW !== 1'b0 || bus.byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got=RW%b/rdy%b exp=0/0", bus.RW, bus.byte_ready);
    end
    checks++;
    if (bus.IAddr !== 32'd0 || bus.IDataIn !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus got=%08h/%08h exp=0/0", bus.IAddr, bus.IDataIn);
    end
    checks++;
    if ({busy, done, err} !== 3'b000 || skip_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_status got=%b%b%b skip=%0d exp=000 skip=0", busy, done, err, skip_cnt);
    end
    do_reset();
  endtask

  task automatic test_single();
    int base = pa.size();
    start_load(32'd8, 8'd1);
    checks++;
    if (busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_collect got=busy%b rdy%b exp=1/1", busy, bus.byte_ready);
    end
    send_word(32'h0801_0001, 1'b0);
    // SETUP
    checks++;
    if (bus.byte_ready !== 1'b0 || bus.RW !== 1'b0 || bus.IAddr !== 32'd8) begin
      failures++;
      $display("FAIL single_setup got=rdy%b RW%b addr=%08h exp=0/0/00000008",
               bus.byte_ready, bus.RW, bus.IAddr);
    end
    tick();
    checks++;
    if (bus.RW !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL single_write got=RW%b done%b exp=1/0", bus.RW, done);
    end
    tick();
    checks++;
    if (bus.RW !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL single_hold got=RW%b done%b exp=0/0", bus.RW, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || skip_cnt !== 8'd0) begin
      failures++;
      $display("FAIL single_done got=done%b err%b skip=%0d exp=1/0/0", done, err, skip_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.IAddr !== 32'd8 || bus.IDataIn !== 32'h0801_0001) begin
      failures++;
      $display("FAIL single_idle got=busy%b done%b %08h/%08h exp=0/0 00000008/08010001",
               busy, done, bus.IAddr, bus.IDataIn);
    end
    checks++;
    if (pa.size() - base != 1) begin
      failures++;
      $display("FAIL single_pulses got=%0d exp=1", pa.size() - base);
    end else if (pa[base] !== 32'd8 || pd[base] !== 32'h0801_0001) begin
      checks++;
      failures++;
      $display("FAIL single_word got=%08h/%08h exp=00000008/08010001", pa[base], pd[base]);
    end
  endtask

  task automatic test_stall();
    int base  = pa.size();
    int rwc   = rw_cycles;
    int glc   = glitches;
    start_load(32'd8, 8'd2);
    send_word(32'hA1B2_C3D4, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    wait_done(20);
    tick();
    checks++;
    if (pa.size() - base != 2 || rw_cycles - rwc != 2) begin
      failures++;
      $display("FAIL stall_pulses got=%0d pulses %0d cycles exp=2/2", pa.size() - base, rw_cycles - rwc);
    end else begin
      checks++;
      if (pa[base] !== 32'd8 || pd[base] !== 32'hA1B2_C3D4 ||
          pa[base+1] !== 32'd12 || pd[base+1] !== 32'h5566_7788) begin
        failures++;
        $display("FAIL stall_words got=%08h/%08h %08h/%08h exp=00000008/a1b2c3d4 0000000c/55667788",
                 pa[base], pd[base], pa[base+1], pd[base+1]);
      end
    end
    checks++;
    if (glitches != glc) begin
      failures++;
      $display("FAIL stall_bus_stable got=%0d changes exp=0", glitches - glc);
    end
  endtask

  task automatic test_skip();
    int base = pa.size();
    start_load(32'd0, 8'd2);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    wait_done(20);
    checks++;
    if (err !== 1'b0 || skip_cnt !== 8'd2) begin
      failures++;
      $display("FAIL skip_count got=err%b skip=%0d exp=0/2", err, skip_cnt);
    end
    tick();
    checks++;
    if (pa.size() - base != 2) begin
      failures++;
      $display("FAIL skip_pulses got=%0d exp=2", pa.size() - base);
    end else if (pa[base] !== 32'd0 || pd[base] !== 32'h1122_3344 ||
                 pa[base+1] !== 32'd4 || pd[base+1] !== 32'd0) begin
      checks++;
      failures++;
      $display("FAIL skip_words got=%08h/%08h %08h/%08h exp=0/11223344 4/0",
               pa[base], pd[base], pa[base+1], pd[base+1]);
    end
  endtask

  task automatic test_errors();
    int base = pa.size();
    start_load(32'd6, 8'd1);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || bus.RW !== 1'b0) begin
      failures++;
      $display("FAIL err_misaligned got=done%b err%b RW%b exp=1/1/0", done, err, bus.RW);
    end
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_held got=done%b err%b busy%b exp=0/1/0", done, err, busy);
    end
    start_load(32'd8, 8'd16);
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_bound16 got=done%b err%b exp=1/1", done, err);
    end
    tick();
    start_load(32'd8, 8'd15);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_bound15 got=err%b busy%b rdy%b exp=0/1/1", err, busy, bus.byte_ready);
    end
    checks++;
    if (pa.size() != base) begin
      failures++;
      $display("FAIL err_no_write got=%0d pulses exp=0", pa.size() - base);
    end
    for (int i = 0; i < 15; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
    wait_done(20);
    checks++;
    if (err !== 1'b0 || skip_cnt !== 8'd0) begin
      failures++;
      $display("FAIL err_full_load got=err%b skip=%0d exp=0/0", err, skip_cnt);
    end
    tick();
    checks++;
    if (pa.size() - base != 15) begin
      failures++;
      $display("FAIL err_full_pulses got=%0d exp=15", pa.size() - base);
    end else if (pa[base+14] !== 32'd64 || pd[base+14] !== 32'h1000_000E) begin
      checks++;
      failures++;
      $display("FAIL err_full_last got=%08h/%08h exp=00000040/1000000e", pa[base+14], pd[base+14]);
    end
  endtask

  task automatic test_async_reset();
    int base;
    start_load(32'd0, 8'd2);
    send_word(32'hAABB_CCDD, 1'b0);
    send_word(32'h0102_0304, 1'b0);
    checks++;
    if (skip_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rst_pre_skip got=%0d exp=1", skip_cnt);
    end
    tick();
    checks++;
    if (bus.RW !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_write got=RW%b exp=1", bus.RW);
    end
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if (bus.RW !== 1'b0 || busy !== 1'b0 || skip_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_async got=RW%b busy%b skip=%0d exp=0/0/0", bus.RW, busy, skip_cnt);
    end
    RST = 1'b1;
    tick();
    base = pa.size();
    start_load(32'd16, 8'd1);
    send_word(32'h0BAD_F00D, 1'b0);
    wait_done(20);
    checks++;
    if (err !== 1'b0 || skip_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_reload_status got=err%b skip=%0d exp=0/0", err, skip_cnt);
    end
    tick();
    checks++;
    if (pa.size() - base != 1) begin
      failures++;
      $display("FAIL rst_reload_pulses got=%0d exp=1", pa.size() - base);
    end else if (pa[base] !== 32'd16 || pd[base] !== 32'h0BAD_F00D) begin
      checks++;
      failures++;
      $display("FAIL rst_reload_word got=%08h/%08h exp=00000010/0badf00d", pa[base], pd[base]);
    end
  endtask

  task automatic test_ignore_start();
    int base = pa.size();
    start_load(32'd8, 8'd1);
    start      = 1'b1;
    start_addr = 32'd20;
    word_cnt   = 8'd3;
    tick();
    start      = 1'b0;
    send_word(32'h1234_5678, 1'b0);
    wait_done(20);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_not_queued got=busy%b exp=0", busy);
    end
    checks++;
    if (pa.size() - base != 1) begin
      failures++;
      $display("FAIL ign_pulses got=%0d exp=1", pa.size() - base);
    end else if (pa[base] !== 32'd8 || pd[base] !== 32'h1234_5678) begin
      checks++;
      failures++;
      $display("FAIL ign_word got=%08h/%08h exp=00000008/12345678", pa[base], pd[base]);
    end
    // Zero-length load with a byte waiting: nothing may be taken.
    base           = pa.size();
    bus.byte_in    = 8'hFF;
    bus.byte_valid = 1'b1;
    start_load(32'd8, 8'd0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || bus.byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL cnt0_done got=done%b err%b rdy%b exp=1/0/0", done, err, bus.byte_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.byte_ready !== 1'b0 || pa.size() != base) begin
      failures++;
      $display("FAIL cnt0_idle got=busy%b done%b rdy%b pulses=%0d exp=0/0/0/0",
               busy, done, bus.byte_ready, pa.size() - base);
    end
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_skip();
    test_errors();
    test_async_reset();
    test_ignore_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
